// File: rtl/sap_pkg.sv
// sap_pkg -- shared constants for the SAP-1 datapath and its controller.
//   SIG_*     : bit positions inside the 12-bit control word
//   OP_*      : instruction opcodes (ir[7:4])
//   PROG_INIT : RAM image used when the program port is not built
//               (macro SAP_PROG_PORT_EN undefined)
package sap_pkg;

  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 4;
  localparam int CTRL_W    = 12;
  localparam int RAM_DEPTH = 1 << ADDR_W;

  localparam int SIG_HLT       = 11;
  localparam int SIG_PC_INC    = 10;
  localparam int SIG_PC_EN     = 9;
  localparam int SIG_MEM_LOAD  = 8;
  localparam int SIG_MEM_EN    = 7;
  localparam int SIG_IR_LOAD   = 6;
  localparam int SIG_IR_EN     = 5;
  localparam int SIG_A_LOAD    = 4;
  localparam int SIG_A_EN      = 3;
  localparam int SIG_B_LOAD    = 2;
  localparam int SIG_ADDER_SUB = 1;
  localparam int SIG_ADDER_EN  = 0;

  typedef enum logic [3:0] {
    OP_LDA = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_HLT = 4'hF
  } opcode_e;

  // Word 0 is an ADD 0xE instruction; the rest are operands handy for bring-up.
  localparam logic [DATA_W-1:0] PROG_INIT [RAM_DEPTH] = '{
    8'h1E, 8'h2F, 8'h55, 8'h05, 8'hFF, 8'h01, 8'h02, 8'h03,
    8'h44, 8'h9C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03, 8'hF0
  };

endpackage

// File: rtl/sap_ram.sv
// sap_ram -- 16x8 program/data RAM, asynchronous read.
//   clk     : write clock (rising edge)
//   raddr_i : read address (from MAR)
//   rdata_o : read data, combinational
//   we_i/waddr_i/wdata_i : write port, only with SAP_PROG_PORT_EN defined;
//   otherwise the RAM is a ROM holding PROG_INIT.
module sap_ram
  import sap_pkg::*;
(
  input  logic       clk,
`ifdef SAP_PROG_PORT_EN
  input  logic       we_i,
  input  logic [3:0] waddr_i,
  input  logic [7:0] wdata_i,
`endif
  input  logic [3:0] raddr_i,
  output logic [7:0] rdata_o
);

`ifdef SAP_PROG_PORT_EN
  // No reset: contents survive rst_n.
  logic [DATA_W-1:0] mem_q [RAM_DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
`else
  logic unused_clk;
  assign unused_clk = clk;
  assign rdata_o    = PROG_INIT[raddr_i];
`endif

endmodule

// File: rtl/sap_datapath.sv
// sap_datapath -- SAP-1 datapath: PC, MAR, IR, A, B, adder/subtractor,
// shared 8-bit bus and RAM. Driven by an external controller via ctrl.
//   clk, rst_n : clock (rising edge), async active-low reset
//   ctrl       : 12-bit control word (bit map in sap_pkg SIG_*)
//   opcode     : ir[7:4] to the controller
//   out_a      : accumulator A
//   bus        : current bus value; bus_err flags multiple drivers
//   halted     : sticky halt, cleared only by reset
//   carry,zero : ALU flags, captured on ADDER_EN & A_LOAD
// Optional macro SAP_PROG_PORT_EN adds prog_we/prog_addr/prog_data for RAM
// loading while halted or in reset.
module sap_datapath
  import sap_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] ctrl,
`ifdef SAP_PROG_PORT_EN
  input  logic        prog_we,
  input  logic [3:0]  prog_addr,
  input  logic [7:0]  prog_data,
`endif
  output logic [3:0]  opcode,
  output logic [7:0]  out_a,
  output logic [7:0]  bus,
  output logic        bus_err,
  output logic        halted,
  output logic        carry,
  output logic        zero
);

  logic [3:0] pc_q, mar_q;
  logic [7:0] ir_q, a_q, b_q;
  logic       carry_q, zero_q, halted_q;
  logic [7:0] ram_rdata, bus_val, b_op;
  logic [8:0] alu_sum;
  logic [4:0] drv;

  sap_ram u_ram (
    .clk     (clk),
`ifdef SAP_PROG_PORT_EN
    .we_i    (prog_we & (halted_q | ~rst_n)),
    .waddr_i (prog_addr),
    .wdata_i (prog_data),
`endif
    .raddr_i (mar_q),
    .rdata_o (ram_rdata)
  );

  // Subtract as a + ~b + 1; bit 8 is the carry out.
  assign b_op    = ctrl[SIG_ADDER_SUB] ? ~b_q : b_q;
  assign alu_sum = {1'b0, a_q} + {1'b0, b_op} + {8'h00, ctrl[SIG_ADDER_SUB]};

  assign drv = {ctrl[SIG_ADDER_EN], ctrl[SIG_A_EN], ctrl[SIG_IR_EN],
                ctrl[SIG_MEM_EN], ctrl[SIG_PC_EN]};

  always_comb begin
    bus_val = 8'h00;
    if      (ctrl[SIG_ADDER_EN]) bus_val = alu_sum[7:0];
    else if (ctrl[SIG_A_EN])     bus_val = a_q;
    else if (ctrl[SIG_IR_EN])    bus_val = {4'h0, ir_q[3:0]};
    else if (ctrl[SIG_MEM_EN])   bus_val = ram_rdata;
    else if (ctrl[SIG_PC_EN])    bus_val = {4'h0, pc_q};
  end

  // More than one bit set <=> clearing the lowest set bit leaves something.
  assign bus_err = |(drv & (drv - 5'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= '0;
      mar_q    <= '0;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      if (ctrl[SIG_HLT]) halted_q <= 1'b1;
      if (!halted_q) begin
        if (ctrl[SIG_PC_INC])   pc_q  <= pc_q + 4'd1;
        if (ctrl[SIG_MEM_LOAD]) mar_q <= bus_val[3:0];
        if (ctrl[SIG_IR_LOAD])  ir_q  <= bus_val;
        if (ctrl[SIG_A_LOAD])   a_q   <= bus_val;
        if (ctrl[SIG_B_LOAD])   b_q   <= bus_val;
        if (ctrl[SIG_ADDER_EN] && ctrl[SIG_A_LOAD]) begin
          carry_q <= alu_sum[8];
          zero_q  <= (alu_sum[7:0] == 8'h00);
        end
      end
    end
  end

  assign opcode = ir_q[7:4];
  assign out_a  = a_q;
  assign bus    = bus_val;
  assign halted = halted_q;
  assign carry  = carry_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_sap_datapath.sv
// tb_sap_datapath -- scoreboard bench for sap_datapath (default build, RAM
// holds PROG_INIT). Internal registers are observed through the bus.
module tb_sap_datapath;

  localparam logic [11:0] HLT = 12'h800, PC_INC = 12'h400, PC_EN = 12'h200,
    MEM_LOAD = 12'h100, MEM_EN = 12'h080, IR_LOAD = 12'h040, IR_EN = 12'h020,
    A_LOAD = 12'h010, A_EN = 12'h008, B_LOAD = 12'h004, ADD_SUB = 12'h002,
    ADD_EN = 12'h001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] ctrl = '0;
  logic [3:0]  opcode;
  logic [7:0]  out_a, bus;
  logic        bus_err, halted, carry, zero;
`ifdef SAP_PROG_PORT_EN
  logic        prog_we = 1'b0;
  logic [3:0]  prog_addr = '0;
  logic [7:0]  prog_data = '0;
`endif

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  exp_q [$];
  logic [7:0]  e, v;
  logic [3:0]  m_pc = '0;

  sap_datapath dut (
    .clk(clk), .rst_n(rst_n), .ctrl(ctrl),
`ifdef SAP_PROG_PORT_EN
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
`endif
    .opcode(opcode), .out_a(out_a), .bus(bus), .bus_err(bus_err),
    .halted(halted), .carry(carry), .zero(zero)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic step(input logic [11:0] c);
    @(negedge clk);
    ctrl = c;
    @(posedge clk);
    #1;
    ctrl = '0;
    if (c[10]) m_pc = m_pc + 4'd1;
  endtask

  task automatic peek(input logic [11:0] c, output logic [7:0] r);
    ctrl = c;
    #1;
    r = bus;
    ctrl = '0;
  endtask

  task automatic goto_pc(input logic [3:0] t);
    while (m_pc != t) step(PC_INC);
  endtask

  task automatic load_reg(input logic [3:0] addr, input logic [11:0] ld);
    goto_pc(addr);
    step(PC_EN | MEM_LOAD);
    step(MEM_EN | ld);
  endtask

  task automatic test_reset();
    #12;
    exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    checks++; e = exp_q.pop_front(); if (out_a !== e) begin failures++; $display("FAIL por_a got=%h exp=%h", out_a, e); end
    checks++; e = exp_q.pop_front(); if ({7'b0, halted} !== e) begin failures++; $display("FAIL por_halted got=%b exp=%h", halted, e); end
    checks++; e = exp_q.pop_front(); if ({7'b0, carry} !== e) begin failures++; $display("FAIL por_carry got=%b exp=%h", carry, e); end
    checks++; e = exp_q.pop_front(); if ({7'b0, zero} !== e) begin failures++; $display("FAIL por_zero got=%b exp=%h", zero, e); end
    checks++; e = exp_q.pop_front(); if (bus !== e) begin failures++; $display("FAIL por_bus got=%h exp=%h", bus, e); end
    @(negedge clk); rst_n = 1'b1; m_pc = '0;
    // Build up a=0x55, pc=7, then reset in the middle of a low phase.
    load_reg(4'd2, A_LOAD);
    goto_pc(4'd7);
    exp_q.push_back(8'h55);
    checks++; e = exp_q.pop_front(); if (out_a !== e) begin failures++; $display("FAIL pre_a got=%h exp=%h", out_a, e); end
    @(negedge clk);
    ctrl = PC_INC | A_LOAD;
    #1 rst_n = 1'b0;
    exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    #1;
    checks++; e = exp_q.pop_front(); if (out_a !== e) begin failures++; $display("FAIL rst_a got=%h exp=%h", out_a, e); end
    checks++; e = exp_q.pop_front(); if ({7'b0, halted} !== e) begin failures++; $display("FAIL rst_halted got=%b exp=%h", halted, e); end
    peek(PC_EN, v);
    checks++; e = exp_q.pop_front(); if (v !== e) begin failures++; $display("FAIL rst_pc got=%h exp=%h", v, e); end
    peek(IR_EN, v);
    checks++; e = exp_q.pop_front(); if (v !== e) begin failures++; $display("FAIL rst_ir got=%h exp=%h", v, e); end
    checks++; e = exp_q.pop_front(); if ({4'h0, opcode} !== e) begin failures++; $display("FAIL rst_opcode got=%h exp=%h", opcode, e); end
    #1;
    checks++; e = exp_q.pop_front(); if (bus !== e) begin failures++; $display("FAIL rst_bus got=%h exp=%h", bus, e); end
    exp_q.push_back(8'h1E);
    peek(MEM_EN, v);
    checks++; e = exp_q.pop_front(); if (v !== e) begin failures++; $display("FAIL rst_ram got=%h exp=%h", v, e); end
    @(negedge clk); rst_n = 1'b1; m_pc = '0;
  endtask

  task automatic test_fetch();
    // First edge after release acts on ctrl.
    exp_q.push_back(8'h01); exp_q.push_back(8'h0E); exp_q.push_back(8'h01);
    exp_q.push_back(8'h1E);
    step(PC_EN | MEM_LOAD);
    step(PC_INC);
    step(MEM_EN | IR_LOAD);
    checks++; e = exp_q.pop_front(); if ({4'h0, opcode} !== e) begin failures++; $display("FAIL fetch_opcode got=%h exp=%h", opcode, e); end
    peek(IR_EN, v);
    checks++; e = exp_q.pop_front(); if (v !== e) begin failures++; $display("FAIL fetch_ir got=%h exp=%h", v, e); end
    peek(PC_EN, v);
    checks++; e = exp_q.pop_front(); if (v !== e) begin failures++; $display("FAIL fetch_pc got=%h exp=%h", v, e); end
    peek(MEM_EN, v);
    checks++; e = exp_q.pop_front(); if (v !== e) begin failures++; $display("FAIL fetch_mar got=%h exp=%h", v, e); end
  endtask

  task automatic test_add();
    load_reg(4'd3, A_LOAD);          // a = 0x05
    step(IR_EN | MEM_LOAD);          // mar = ir[3:0] = 0xE
    step(MEM_EN | B_LOAD);           // b = 0x03
    exp_q.push_back(8'h08);
    peek(ADD_EN, v);
    checks++; e = exp_q.pop_front(); if (v !== e) begin failures++; $display("FAIL add_bus got=%h exp=%h", v, e); end
    exp_q.push_back(8'h08); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    step(ADD_EN | A_LOAD);
    checks++; e = exp_q.pop_front(); if (out_a !== e) begin failures++; $display("FAIL add_a got=%h exp=%h", out_a, e); end
    checks++; e = exp_q.pop_front(); if ({7'b0, carry} !== e) begin failures++; $display("FAIL add_carry got=%b exp=%h", carry, e); end
    checks++; e = exp_q.pop_front(); if ({7'b0, zero} !== e) begin failures++; $display("FAIL add_zero got=%b exp=%h", zero, e); end
    load_reg(4'd4, A_LOAD);          // a = 0xFF
    load_reg(4'd5, B_LOAD);          // b = 0x01
    exp_q.push_back(8'h00); exp_q.push_back(8'h01); exp_q.push_back(8'h01);
    step(ADD_EN | A_LOAD);
    checks++; e = exp_q.pop_front(); if (out_a !== e) begin failures++; $display("FAIL addc_a got=%h exp=%h", out_a, e); end
    checks++; e = exp_q.pop_front(); if ({7'b0, carry} !== e) begin failures++; $display("FAIL addc_carry got=%b exp=%h", carry, e); end
    checks++; e = exp_q.pop_front(); if ({7'b0, zero} !== e) begin failures++; $display("FAIL addc_zero got=%b exp=%h", zero, e); end
    // ADDER_EN without A_LOAD: flags must hold.
    exp_q.push_back(8'h01); exp_q.push_back(8'h01);
    step(ADD_EN);
    checks++; e = exp_q.pop_front(); if ({7'b0, carry} !== e) begin failures++; $display("FAIL hold_carry got=%b exp=%h", carry, e); end
    checks++; e = exp_q.pop_front(); if ({7'b0, zero} !== e) begin failures++; $display("FAIL hold_zero got=%b exp=%h", zero, e); end
  endtask

  task automatic test_sub();
    load_reg(4'd6, A_LOAD);          // a = 0x02
    load_reg(4'd7, B_LOAD);          // b = 0x03
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    step(ADD_SUB | ADD_EN | A_LOAD);
    checks++; e = exp_q.pop_front(); if (out_a !== e) begin failures++; $display("FAIL sub_a got=%h exp=%h", out_a, e); end
    checks++; e = exp_q.pop_front(); if ({7'b0, carry} !== e) begin failures++; $display("FAIL sub_carry got=%b exp=%h", carry, e); end
    checks++; e = exp_q.pop_front(); if ({7'b0, zero} !== e) begin failures++; $display("FAIL sub_zero got=%b exp=%h", zero, e); end
    exp_q.push_back(8'hFF);
    step(A_LOAD | A_EN);
    checks++; e = exp_q.pop_front(); if (out_a !== e) begin failures++; $display("FAIL self_load_a got=%h exp=%h", out_a, e); end
    goto_pc(4'd15);
    exp_q.push_back(8'h0F); exp_q.push_back(8'h00);
    @(negedge clk);
    ctrl = PC_EN | PC_INC;
    #1;
    checks++; e = exp_q.pop_front(); if (bus !== e) begin failures++; $display("FAIL preinc_bus got=%h exp=%h", bus, e); end
    @(posedge clk); #1; ctrl = '0; m_pc = 4'd0;
    peek(PC_EN, v);
    checks++; e = exp_q.pop_front(); if (v !== e) begin failures++; $display("FAIL pc_wrap got=%h exp=%h", v, e); end
  endtask

  task automatic test_conflict();
    load_reg(4'd9, A_LOAD);          // a = 0x9C, b still 0x03
    goto_pc(4'd3);
    exp_q.push_back(8'h9C); exp_q.push_back(8'h01);
    ctrl = PC_EN | A_EN;
    #1;
    checks++; e = exp_q.pop_front(); if (bus !== e) begin failures++; $display("FAIL conf_bus got=%h exp=%h", bus, e); end
    checks++; e = exp_q.pop_front(); if ({7'b0, bus_err} !== e) begin failures++; $display("FAIL conf_err got=%b exp=%h", bus_err, e); end
    exp_q.push_back(8'h9F);
    ctrl = PC_EN | A_EN | ADD_EN;
    #1;
    checks++; e = exp_q.pop_front(); if (bus !== e) begin failures++; $display("FAIL conf_prio got=%h exp=%h", bus, e); end
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    ctrl = '0;
    #1;
    checks++; e = exp_q.pop_front(); if ({7'b0, bus_err} !== e) begin failures++; $display("FAIL idle_err got=%b exp=%h", bus_err, e); end
    checks++; e = exp_q.pop_front(); if (bus !== e) begin failures++; $display("FAIL idle_bus got=%h exp=%h", bus, e); end
  endtask

  task automatic test_halt();
    goto_pc(4'd8);
    step(PC_EN | MEM_LOAD);          // mar = 8, ram[8] = 0x44
    exp_q.push_back(8'h01);
    step(HLT);
    checks++; e = exp_q.pop_front(); if ({7'b0, halted} !== e) begin failures++; $display("FAIL halt_set got=%b exp=%h", halted, e); end
    exp_q.push_back(8'h44); exp_q.push_back(8'h9C); exp_q.push_back(8'h01);
    exp_q.push_back(8'h08);
    @(negedge clk);
    ctrl = PC_INC | A_LOAD | MEM_EN;
    #1;
    checks++; e = exp_q.pop_front(); if (bus !== e) begin failures++; $display("FAIL halt_bus got=%h exp=%h", bus, e); end
    @(posedge clk); #1; ctrl = '0;
    checks++; e = exp_q.pop_front(); if (out_a !== e) begin failures++; $display("FAIL halt_a got=%h exp=%h", out_a, e); end
    checks++; e = exp_q.pop_front(); if ({7'b0, halted} !== e) begin failures++; $display("FAIL halt_sticky got=%b exp=%h", halted, e); end
    peek(PC_EN, v);
    checks++; e = exp_q.pop_front(); if (v !== e) begin failures++; $display("FAIL halt_pc got=%h exp=%h", v, e); end
    exp_q.push_back(8'h00);
    @(negedge clk); rst_n = 1'b0;
    #1;
    checks++; e = exp_q.pop_front(); if ({7'b0, halted} !== e) begin failures++; $display("FAIL halt_clear got=%b exp=%h", halted, e); end
    #1 rst_n = 1'b1; m_pc = '0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_add();
    test_sub();
    test_conflict();
    test_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
